instruction_fetch_buffer: RTL and testbench
===========================================

# instruction_fetch_buffer

Prefetch stage directly upstream of instruction decode in ExperiarCore. Issues word-aligned instruction reads on a single-outstanding request/acknowledge memory port and buffers returned words with their PCs in a small FIFO. Presents the head entry as `currentInstruction`, with a `stall` flag that feeds decode's `stall` input. Handles pipeline redirects (jumps, branches, traps), discards in-flight data, and reports fetch faults.

## Interface
- `RESET_ADDRESS`, default 32'h0000_0000: first fetch PC after reset; must be word-aligned.
- `DEPTH`, default 2: FIFO entries; power of two, 2..8.

- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `jumpEnable` input 1: redirect fetch this cycle.
- `jumpAddress` input 32: redirect target.
- `advance` input 1: consumer accepted the head entry this cycle.
- `currentInstruction` output 32: head entry instruction word.
- `currentPC` output 32: head entry PC.
- `stall` output 1: high when no valid head entry.
- `fetchFault` output 1: head entry came from a bus error, or fetch is halted on a misaligned target.
- `memoryAddress` output 32: read address.
- `memoryRequest` output 1: read request.
- `memoryAck` input 1: read completes this cycle.
- `memoryReadData` input 32: read data, valid with `memoryAck`.
- `memoryBusError` input 1: error flag, valid with `memoryAck`.

## Operation
- State: `fetchPC`, FIFO (data, PC, fault bit per entry), `count`, FSM, `halted` flag.
- FSM states: IDLE, REQUEST and DISCARD.
  - `memoryRequest` = (state is REQUEST or DISCARD).
  - `memoryAddress` = `fetchPC`. It is held stable while a request is pending.
- IDLE to REQUEST when `count` < DEPTH, `halted` = 0, and no `jumpEnable`.
- REQUEST with `memoryAck`:
  - Push {`memoryReadData`, `fetchPC`, `memoryBusError`}.
  - `fetchPC` += 4, modulo 2^32.
  - Stay in REQUEST if post-push/pop count < DEPTH and no error. Otherwise go to IDLE.
- Bus error: the faulting entry is pushed and `halted` is set. No further requests are issued until a jump.
- `jumpEnable` has priority over everything:
  - FIFO is cleared (`count` := 0) and `halted` is cleared.
  - `fetchPC` := `jumpAddress`.
  - If `jumpAddress[1:0]` != 0, `halted` is set and the fault is reported as below. No request is issued.
  - Jump in REQUEST without ack: go to DISCARD.
  - Jump in REQUEST with ack: data is dropped; go to IDLE.
  - Jump in DISCARD: `fetchPC` is updated and the state is unchanged.
- DISCARD with `memoryAck`: the response is dropped; go to IDLE. Nothing is pushed and `fetchPC` is not incremented.
- Head outputs:
  - FIFO non-empty: the head entry, `stall` = 0, `fetchFault` = entry fault bit.
  - FIFO empty: `currentInstruction` = 0, `currentPC` = 0, `stall` = 1.
  - `fetchFault` = 1 when empty and halted on a misaligned target. In that case `currentPC` = `fetchPC`.
- `advance` pops the head only when non-empty; `advance` while empty is ignored.
- Push and pop in the same cycle leave `count` unchanged. This is legal even when full, because the full check uses the post-pop count.
- Fault entries are popped normally; the consumer decides trap behaviour.

## Timing
- Reset values:
  - State IDLE, `count` 0, `halted` 0, `fetchPC` = `RESET_ADDRESS`.
  - `memoryRequest` 0, `memoryAddress` = `RESET_ADDRESS`.
  - `stall` 1, `currentInstruction` 0, `currentPC` 0, `fetchFault` 0.
- Reset asserted mid-request drops the transaction immediately (asynchronous). A later stray `memoryAck` in IDLE is ignored.
- First request is asserted 1 cycle after `rst_n` deassertion: cycle 0 is IDLE, cycle 1 is REQUEST.
- Ack at cycle k makes the entry visible at cycle k+1, with `stall` low.
- Back-to-back acks give 1 instruction/cycle while space remains.
- Jump at cycle j: `stall` = 1 at j+1.
  - If idle, new `memoryAddress` is presented with `memoryRequest` at j+1.
  - If a request was pending, the new request follows 1 cycle after the discarded ack.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.

## Test plan
- Reset release, ack every cycle from 1 → addresses 0x0, 0x4, 0x8 requested on consecutive cycles. `currentPC` 0x0 with `stall` 0 one cycle after the first ack.
- `advance` = 0 with DEPTH = 2 → `memoryRequest` drops after 2 acks and `count` = 2. One `advance` pulse → 1 entry popped and the request to 0x8 reasserted next cycle.
- `jumpEnable` to 0x100 while a request to 0x8 is pending, ack 3 cycles later with 0xDEADBEEF → not pushed. Next request to 0x100, and `currentPC` = 0x100 after its ack.
- Ack with `memoryBusError` at 0x4 → entry with `fetchFault` 1 and no further requests. Jump to 0x40 → fetch resumes at 0x40 and `fetchFault` 0.
- Jump to 0x102 → no request, `stall` 1, `fetchFault` 1, `currentPC` 0x102 held until the next jump.
- `jumpEnable` and `advance` asserted together with the FIFO full → FIFO empty next cycle and request to the jump target. Assert `rst_n` low mid-request → all outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch_buffer.sv
// Prefetch stage ahead of decode: single-outstanding word reads into a small PC-tagged FIFO,
// with redirect handling, in-flight discard and fetch-fault reporting.
//
// state   | meaning
// IDLE    | no read outstanding; waiting for FIFO space, or halted
// REQUEST | read outstanding; response will be pushed
// DISCARD | read outstanding across a redirect; response will be dropped
module instruction_fetch_buffer #(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jumpEnable,
    input  logic [31:0] jumpAddress,
    input  logic        advance,
    output logic [31:0] currentInstruction,
    output logic [31:0] currentPC,
    output logic        stall,
    output logic        fetchFault,
    output logic [31:0] memoryAddress,
    output logic        memoryRequest,
    input  logic        memoryAck,
    input  logic [31:0] memoryReadData,
    input  logic        memoryBusError
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [31:0]      fetchPC;
    logic             halted;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    logic [31:0]      fifoData [DEPTH];
    logic [31:0]      fifoPC   [DEPTH];
    logic [DEPTH-1:0] fifoFault;

    logic isEmpty;
    logic doPush;
    logic doPop;
    logic spaceLeft;
    logic misalignHalt;

    assign isEmpty   = (count == '0);
    assign doPush    = (state == REQUEST) && memoryAck && !jumpEnable;
    assign doPop     = advance && !isEmpty && !jumpEnable;
    assign countNext = count + CNT_W'(doPush) - CNT_W'(doPop);
    assign spaceLeft = (countNext < CNT_W'(DEPTH));

    // fetchPC can only become misaligned through a redirect, so this separates
    // a misaligned-target halt from a bus-error halt
    assign misalignHalt = halted && (fetchPC[1:0] != 2'b00);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (jumpEnable) begin
                    stateNext = (jumpAddress[1:0] == 2'b00) ? REQUEST : IDLE;
                end else if (!halted && spaceLeft) begin
                    stateNext = REQUEST;
                end
            end
            REQUEST: begin
                if (jumpEnable) begin
                    stateNext = memoryAck ? IDLE : DISCARD;
                end else if (memoryAck) begin
                    stateNext = (spaceLeft && !memoryBusError) ? REQUEST : IDLE;
                end
            end
            DISCARD: begin
                if (memoryAck) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fetchPC <= RESET_ADDRESS;
            halted  <= 1'b0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            state <= stateNext;
            if (jumpEnable) begin
                fetchPC <= jumpAddress;
                halted  <= (jumpAddress[1:0] != 2'b00);
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
            end else begin
                count <= countNext;
                if (doPush) begin
                    fetchPC <= fetchPC + 32'd4;
                    wrPtr   <= wrPtr + 1'b1;
                    if (memoryBusError) begin
                        halted <= 1'b1;
                    end
                end
                if (doPop) begin
                    rdPtr <= rdPtr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoData[wrPtr]  <= memoryReadData;
            fifoPC[wrPtr]    <= fetchPC;
            fifoFault[wrPtr] <= memoryBusError;
        end
    end

    assign memoryRequest      = (state == REQUEST) || (state == DISCARD);
    assign memoryAddress      = fetchPC;
    assign stall              = isEmpty;
    assign currentInstruction = isEmpty ? 32'h0 : fifoData[rdPtr];
    assign currentPC          = isEmpty ? (misalignHalt ? fetchPC : 32'h0) : fifoPC[rdPtr];
    assign fetchFault         = isEmpty ? misalignHalt : fifoFault[rdPtr];

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: directed stimulus, with a monitor that checks request
// addresses and popped entries against queues of hand-computed expectations.
module tb_instruction_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jumpEnable = 1'b0;
    logic [31:0] jumpAddress = 32'h0;
    logic        advance = 1'b0;
    logic [31:0] currentInstruction;
    logic [31:0] currentPC;
    logic        stall;
    logic        fetchFault;
    logic [31:0] memoryAddress;
    logic        memoryRequest;
    logic        memoryAck = 1'b0;
    logic [31:0] memoryReadData = 32'h0;
    logic        memoryBusError = 1'b0;

    int passCount = 0;
    int checkCount = 0;

    logic [31:0] addrQ[$];
    logic [64:0] expQ[$];

    instruction_fetch_buffer #(.RESET_ADDRESS(32'h0), .DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .jumpEnable(jumpEnable),
        .jumpAddress(jumpAddress),
        .advance(advance),
        .currentInstruction(currentInstruction),
        .currentPC(currentPC),
        .stall(stall),
        .fetchFault(fetchFault),
        .memoryAddress(memoryAddress),
        .memoryRequest(memoryRequest),
        .memoryAck(memoryAck),
        .memoryReadData(memoryReadData),
        .memoryBusError(memoryBusError)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request, then acks it for one cycle; optionally expects the word in the FIFO
    task automatic ackWith(input logic [31:0] addr, input logic [31:0] data, input logic err,
                           input logic expectPush);
        int n = 0;
        while (!memoryRequest && n < 20) begin
            step();
            n++;
        end
        check("request seen before ack", {31'b0, memoryRequest}, 32'd1);
        addrQ.push_back(addr);
        if (expectPush) expQ.push_back({data, addr, err});
        memoryAck      = 1'b1;
        memoryReadData = data;
        memoryBusError = err;
        step();
        memoryAck      = 1'b0;
        memoryBusError = 1'b0;
        memoryReadData = 32'h0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " memoryRequest"}, {31'b0, memoryRequest}, 32'd0);
        check({tag, " memoryAddress"}, memoryAddress, 32'h0);
        check({tag, " stall"}, {31'b0, stall}, 32'd1);
        check({tag, " currentInstruction"}, currentInstruction, 32'h0);
        check({tag, " currentPC"}, currentPC, 32'h0);
        check({tag, " fetchFault"}, {31'b0, fetchFault}, 32'd0);
    endtask

    // Monitor: request address on every completed ack, head entry on every accepted pop
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && memoryRequest && memoryAck) begin
                if (addrQ.size() == 0) check("unexpected ack address", memoryAddress, 32'hFFFF_FFFF);
                else check("ack address", memoryAddress, addrQ.pop_front());
            end
            if (rst_n && advance && !stall && !jumpEnable) begin
                if (expQ.size() == 0) begin
                    check("unexpected pop PC", currentPC, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check("pop instruction", currentInstruction, e[64:33]);
                    check("pop PC", currentPC, e[32:1]);
                    check("pop fault", {31'b0, fetchFault}, {31'b0, e[0]});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        check("cycle0 no request", {31'b0, memoryRequest}, 32'd0);
        step();
        check("cycle1 request", {31'b0, memoryRequest}, 32'd1);
        check("cycle1 address", memoryAddress, 32'h0);

        // streaming with the consumer popping every cycle
        ackWith(32'h0, 32'hA000_0000, 1'b0, 1'b1);
        check("first entry stall", {31'b0, stall}, 32'd0);
        check("first entry PC", currentPC, 32'h0);
        advance = 1'b1;
        ackWith(32'h4, 32'hA000_0001, 1'b0, 1'b1);
        check("back-to-back address", memoryAddress, 32'h8);
        ackWith(32'h8, 32'hA000_0002, 1'b0, 1'b1);
        advance = 1'b0;
        ackWith(32'hC, 32'hA000_0003, 1'b0, 1'b1);
        check("full drops request", {31'b0, memoryRequest}, 32'd0);
        step();
        check("full holds idle", {31'b0, memoryRequest}, 32'd0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("request after pop", {31'b0, memoryRequest}, 32'd1);
        check("address after pop", memoryAddress, 32'h10);
        check("head after pop", currentPC, 32'hC);

        // redirect while a request is pending; late response is dropped
        jumpEnable = 1'b1;
        jumpAddress = 32'h100;
        expQ.delete();
        step();
        jumpEnable = 1'b0;
        check("jump stall", {31'b0, stall}, 32'd1);
        check("discard address", memoryAddress, 32'h100);
        step();
        step();
        addrQ.push_back(32'h100);
        memoryAck = 1'b1;
        memoryReadData = 32'hDEAD_BEEF;
        step();
        memoryAck = 1'b0;
        check("discarded not pushed", {31'b0, stall}, 32'd1);
        check("idle after discard", {31'b0, memoryRequest}, 32'd0);
        ackWith(32'h100, 32'hB000_0000, 1'b0, 1'b1);
        check("jump target PC", currentPC, 32'h100);
        check("jump target stall", {31'b0, stall}, 32'd0);

        // bus error halts fetch until a redirect
        ackWith(32'h104, 32'hB000_0001, 1'b1, 1'b1);
        check("halt after bus error", {31'b0, memoryRequest}, 32'd0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("fault entry flag", {31'b0, fetchFault}, 32'd1);
        check("fault entry PC", currentPC, 32'h104);
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("empty after fault pop", {31'b0, stall}, 32'd1);
        check("bus halt no fetchFault", {31'b0, fetchFault}, 32'd0);
        repeat (3) step();
        check("still halted", {31'b0, memoryRequest}, 32'd0);
        jumpEnable = 1'b1;
        jumpAddress = 32'h40;
        step();
        jumpEnable = 1'b0;
        check("resume request", {31'b0, memoryRequest}, 32'd1);
        check("resume address", memoryAddress, 32'h40);
        ackWith(32'h40, 32'hC000_0000, 1'b0, 1'b1);
        check("resume PC", currentPC, 32'h40);
        check("resume fault clear", {31'b0, fetchFault}, 32'd0);
        ackWith(32'h44, 32'hC000_0001, 1'b0, 1'b1);

        // misaligned redirect from a full FIFO
        jumpEnable = 1'b1;
        jumpAddress = 32'h102;
        expQ.delete();
        step();
        jumpEnable = 1'b0;
        check("misaligned stall", {31'b0, stall}, 32'd1);
        check("misaligned fault", {31'b0, fetchFault}, 32'd1);
        check("misaligned PC", currentPC, 32'h102);
        check("misaligned no request", {31'b0, memoryRequest}, 32'd0);
        advance = 1'b1;
        step();
        advance = 1'b0;
        repeat (2) step();
        check("misaligned held PC", currentPC, 32'h102);
        check("misaligned held fault", {31'b0, fetchFault}, 32'd1);
        check("misaligned held no request", {31'b0, memoryRequest}, 32'd0);

        // redirect and advance together while full
        jumpEnable = 1'b1;
        jumpAddress = 32'h200;
        step();
        jumpEnable = 1'b0;
        check("post-misalign fault clear", {31'b0, fetchFault}, 32'd0);
        check("post-misalign PC", currentPC, 32'h0);
        ackWith(32'h200, 32'hD000_0000, 1'b0, 1'b1);
        ackWith(32'h204, 32'hD000_0001, 1'b0, 1'b1);
        check("full before jump", {31'b0, memoryRequest}, 32'd0);
        jumpEnable = 1'b1;
        jumpAddress = 32'h300;
        advance = 1'b1;
        expQ.delete();
        step();
        jumpEnable = 1'b0;
        advance = 1'b0;
        check("jump+advance empty", {31'b0, stall}, 32'd1);
        check("jump+advance request", {31'b0, memoryRequest}, 32'd1);
        check("jump+advance address", memoryAddress, 32'h300);

        // asynchronous reset in the middle of a request, then a stray ack
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async reset");
        step();
        rst_n = 1'b1;
        memoryAck = 1'b1;
        memoryReadData = 32'hBAD0_BAD0;
        step();
        memoryAck = 1'b0;
        check("stray ack ignored", {31'b0, stall}, 32'd1);
        check("restart request", {31'b0, memoryRequest}, 32'd1);
        check("restart address", memoryAddress, 32'h0);
        check("all acks accounted", addrQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
